// File: rtl/clint_timer.sv
// -----------------------------------------------------------------------------
// clint_timer
//
// Core-local interrupt source. Owns the machine timer (mtime), the timer
// compare register (mtimecmp) and the software interrupt bit (msip). These are
// reachable through a single-outstanding request/response bus port. It also
// synchronizes the external interrupt line into the clk domain.
//
// Register window, offsets from BASE_ADDR:
//   +0x0000  msip      (bit 0 only, other bits read as 0)
//   +0x4000  mtimecmp  (64 bits)
//   +0xBFF8  mtime     (64 bits)
// Any other address, including a misaligned one, returns resp_err=1 with
// resp_data=0 and leaves all state unchanged.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (req_ready=1 only in IDLE)
//   req_write             1 = write, 0 = read
//   req_addr              byte address
//   req_data/req_strobe   write data and byte enables
//   resp_valid/resp_ready response handshake
//   resp_data/resp_err    read data (0 for writes and errors) / access fault
//   ext_irq               asynchronous external interrupt request
//   trint                 mtime >= mtimecmp (unsigned)
//   swint                 msip
//   exint                 ext_irq after a 2-flop synchronizer
//   mtime_o               current mtime, for the CSR time read path
// -----------------------------------------------------------------------------
module clint_timer #(
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_data,
    input  logic [7:0]  req_strobe,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_data,
    output logic        resp_err,
    input  logic        ext_irq,
    output logic        trint,
    output logic        swint,
    output logic        exint,
    output logic [63:0] mtime_o
);

    // Prescaler is at least one bit wide so TICK_DIV=1 still elaborates;
    // in that case it sits at 0 and every cycle is a tick.
    localparam int unsigned     PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);

    localparam logic [63:0] ADDR_MSIP  = BASE_ADDR + 64'h0000;
    localparam logic [63:0] ADDR_CMP   = BASE_ADDR + 64'h4000;
    localparam logic [63:0] ADDR_MTIME = BASE_ADDR + 64'hBFF8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_e;

    state_e         state_q,     state_d;
    logic [63:0]    mtime_q,     mtime_d;
    logic [63:0]    mtimecmp_q,  mtimecmp_d;
    logic           msip_q,      msip_d;
    logic [PW-1:0]  presc_q,     presc_d;
    logic [1:0]     sync_q,      sync_d;
    logic [63:0]    resp_data_q, resp_data_d;
    logic           resp_err_q,  resp_err_d;

    logic           sel_msip;
    logic           sel_cmp;
    logic           sel_mtime;
    logic           accept;
    logic           tick;

    // Replace only the bytes whose strobe bit is set.
    function automatic logic [63:0] byte_merge(
        input logic [63:0] old_v,
        input logic [63:0] new_v,
        input logic [7:0]  strb
    );
        logic [63:0] r;
        r = old_v;
        for (int i = 0; i < 8; i++) begin
            if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    // Exact-address decode: the three legal addresses are 8-byte aligned,
    // so any addr[2:0] != 0 naturally falls through to the error path.
    assign sel_msip  = (req_addr == ADDR_MSIP);
    assign sel_cmp   = (req_addr == ADDR_CMP);
    assign sel_mtime = (req_addr == ADDR_MTIME);

    assign accept = (state_q == S_IDLE) && req_valid;
    assign tick   = (presc_q == PRESC_MAX);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d     = state_q;
        mtimecmp_d  = mtimecmp_q;
        msip_d      = msip_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        sync_d      = {sync_q[0], ext_irq};

        presc_d = tick ? '0 : presc_q + 1'b1;
        mtime_d = tick ? mtime_q + 64'd1 : mtime_q;

        if (accept) begin
            state_d     = S_RESP;
            resp_err_d  = !(sel_msip || sel_cmp || sel_mtime);
            resp_data_d = '0;
            if (!req_write) begin
                // Reads see the pre-edge register value.
                if (sel_msip)  resp_data_d = {63'b0, msip_q};
                if (sel_cmp)   resp_data_d = mtimecmp_q;
                if (sel_mtime) resp_data_d = mtime_q;
            end else begin
                if (sel_msip && req_strobe[0]) msip_d = req_data[0];
                if (sel_cmp) mtimecmp_d = byte_merge(mtimecmp_q, req_data, req_strobe);
                // A bus write overrides a same-edge tick; the prescaler
                // keeps running untouched.
                if (sel_mtime) mtime_d = byte_merge(mtime_q, req_data, req_strobe);
            end
        end else if (state_q == S_RESP && resp_ready) begin
            state_d = S_IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values computed above.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mtime_q     <= '0;
            mtimecmp_q  <= '1;
            msip_q      <= 1'b0;
            presc_q     <= '0;
            sync_q      <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            msip_q      <= msip_d;
            presc_q     <= presc_d;
            sync_q      <= sync_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign trint      = (mtime_q >= mtimecmp_q);
    assign swint      = msip_q;
    assign exint      = sync_q[1];
    assign mtime_o    = mtime_q;

endmodule
